// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU instruction sequencer family.
// Holds state encoding, opcode values, IR field positions and class enum.
package alu_seq_pkg;

    localparam int IR_WIDTH  = 32;
    localparam int OPC_WIDTH = 5;
    localparam int SEL_WIDTH = 4;

    localparam int OPC_LSB = 27;
    localparam int RA_LSB  = 23;
    localparam int RB_LSB  = 19;
    localparam int RC_LSB  = 15;

    localparam logic [OPC_WIDTH-1:0] OP_ADD = 5'b00011;
    localparam logic [OPC_WIDTH-1:0] OP_SUB = 5'b00100;
    localparam logic [OPC_WIDTH-1:0] OP_AND = 5'b00101;
    localparam logic [OPC_WIDTH-1:0] OP_OR  = 5'b00110;
    localparam logic [OPC_WIDTH-1:0] OP_MUL = 5'b01111;
    localparam logic [OPC_WIDTH-1:0] OP_DIV = 5'b10000;
    localparam logic [OPC_WIDTH-1:0] OP_NEG = 5'b10001;
    localparam logic [OPC_WIDTH-1:0] OP_NOT = 5'b10010;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_DONE = 4'd8,
        S_ERR  = 4'd9
    } state_e;

    typedef enum logic [1:0] {
        CLS_BIN,
        CLS_WIDE,
        CLS_UNARY,
        CLS_ILLEGAL
    } instr_cls_e;

    function automatic instr_cls_e opc_class(logic [OPC_WIDTH-1:0] opc);
        instr_cls_e c;
        case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR: c = CLS_BIN;
            OP_MUL, OP_DIV:                c = CLS_WIDE;
            OP_NEG, OP_NOT:                c = CLS_UNARY;
            default:                       c = CLS_ILLEGAL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational instruction field decoder: ir -> class, register selects, opcode.
// Shared with the other per-class sequencers.
module alu_seq_decode
    import alu_seq_pkg::*;
#(
    parameter int OPC_W = OPC_WIDTH,
    parameter int SEL_W = SEL_WIDTH
) (
    input  logic [IR_WIDTH-1:0] ir,
    output instr_cls_e          cls,
    output logic [SEL_W-1:0]    ra,
    output logic [SEL_W-1:0]    rb,
    output logic [SEL_W-1:0]    rc,
    output logic [OPC_W-1:0]    opcode
);

    // Low-order immediate bits belong to other instruction formats.
    logic unused_low;

    assign opcode = ir[OPC_LSB +: OPC_W];
    assign ra     = ir[RA_LSB +: SEL_W];
    assign rb     = ir[RB_LSB +: SEL_W];
    assign rc     = ir[RC_LSB +: SEL_W];
    assign cls    = opc_class(opcode);

    assign unused_low = ^ir[RC_LSB-1:0];

endmodule

// File: rtl/alu_instr_sequencer.sv
// Moore control unit sequencing fetch (T0-T2) and execute (T3-T6)
// of register-register ALU instructions on the phase-1 datapath.
module alu_instr_sequencer
    import alu_seq_pkg::*;
#(
    parameter int OPC_W        = 5,
    parameter int SEL_W        = 4,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [31:0]      ir,
    input  logic             mem_ready,
    output logic             pc_out,
    output logic             mar_in,
    output logic             inc_pc,
    output logic             mem_read,
    output logic             mdr_in,
    output logic             mdr_out,
    output logic             ir_in,
    output logic             y_in,
    output logic             z_in,
    output logic             zlo_out,
    output logic             zhi_out,
    output logic             hi_in,
    output logic             lo_in,
    output logic             reg_out_en,
    output logic [SEL_W-1:0] reg_out_sel,
    output logic             reg_in_en,
    output logic [SEL_W-1:0] reg_in_sel,
    output logic [OPC_W-1:0] alu_op,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    instr_cls_e        cls;
    logic [SEL_W-1:0]  ra, rb, rc;
    logic [OPC_W-1:0]  opc;

    alu_seq_decode #(
        .OPC_W (OPC_W),
        .SEL_W (SEL_W)
    ) u_decode (
        .ir     (ir),
        .cls    (cls),
        .ra     (ra),
        .rb     (rb),
        .rc     (rc),
        .opcode (opc)
    );

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            S_IDLE: if (start) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1: begin
                if (mem_ready) begin
                    state_d = S_T2;
                    wait_d  = '0;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_ERR;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_T2:   state_d = S_T3;
            S_T3:   state_d = (cls == CLS_ILLEGAL) ? S_ERR : S_T4;
            S_T4:   state_d = (cls == CLS_UNARY) ? S_DONE : S_T5;
            S_T5:   state_d = (cls == CLS_BIN) ? S_DONE : S_T6;
            S_T6:   state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            S_ERR:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Each state drives at most one bus source; selects read 0 when unused.
    always_comb begin
        pc_out      = 1'b0;
        mar_in      = 1'b0;
        inc_pc      = 1'b0;
        mem_read    = 1'b0;
        mdr_in      = 1'b0;
        mdr_out     = 1'b0;
        ir_in       = 1'b0;
        y_in        = 1'b0;
        z_in        = 1'b0;
        zlo_out     = 1'b0;
        zhi_out     = 1'b0;
        hi_in       = 1'b0;
        lo_in       = 1'b0;
        reg_out_en  = 1'b0;
        reg_out_sel = '0;
        reg_in_en   = 1'b0;
        reg_in_sel  = '0;
        alu_op      = '0;
        done        = 1'b0;
        err         = 1'b0;
        unique case (state_q)
            S_T0: begin
                pc_out = 1'b1;
                mar_in = 1'b1;
                inc_pc = 1'b1;
                z_in   = 1'b1;
            end
            S_T1: begin
                zlo_out  = 1'b1;
                mem_read = 1'b1;
                mdr_in   = 1'b1;
            end
            S_T2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
            end
            S_T3: begin
                unique case (cls)
                    CLS_BIN: begin
                        reg_out_en  = 1'b1;
                        reg_out_sel = rb;
                        y_in        = 1'b1;
                    end
                    CLS_WIDE: begin
                        reg_out_en  = 1'b1;
                        reg_out_sel = ra;
                        y_in        = 1'b1;
                    end
                    CLS_UNARY: begin
                        reg_out_en  = 1'b1;
                        reg_out_sel = rb;
                        alu_op      = opc;
                        z_in        = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                unique case (cls)
                    CLS_BIN: begin
                        reg_out_en  = 1'b1;
                        reg_out_sel = rc;
                        alu_op      = opc;
                        z_in        = 1'b1;
                    end
                    CLS_WIDE: begin
                        reg_out_en  = 1'b1;
                        reg_out_sel = rb;
                        alu_op      = opc;
                        z_in        = 1'b1;
                    end
                    CLS_UNARY: begin
                        zlo_out    = 1'b1;
                        reg_in_en  = 1'b1;
                        reg_in_sel = ra;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                unique case (cls)
                    CLS_BIN: begin
                        zlo_out    = 1'b1;
                        reg_in_en  = 1'b1;
                        reg_in_sel = ra;
                    end
                    CLS_WIDE: begin
                        zlo_out = 1'b1;
                        lo_in   = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                zhi_out = 1'b1;
                hi_in   = 1'b1;
            end
            S_DONE: done = 1'b1;
            S_ERR:  err  = 1'b1;
            default: ;
        endcase
    end

    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Directed bench for alu_instr_sequencer: per-cycle strobe, select and
// opcode checks across ALU classes, errors, timeout and abort.
module tb_alu_instr_sequencer;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [31:0] ir;
    logic        mem_ready;
    logic        pc_out, mar_in, inc_pc, mem_read, mdr_in, mdr_out, ir_in;
    logic        y_in, z_in, zlo_out, zhi_out, hi_in, lo_in;
    logic        reg_out_en, reg_in_en;
    logic [3:0]  reg_out_sel, reg_in_sel;
    logic [4:0]  alu_op;
    logic        busy, done, err;

    int checks   = 0;
    int failures = 0;

    localparam logic [17:0] M_PC   = 18'h20000;
    localparam logic [17:0] M_MAR  = 18'h10000;
    localparam logic [17:0] M_INC  = 18'h08000;
    localparam logic [17:0] M_MRD  = 18'h04000;
    localparam logic [17:0] M_MDRI = 18'h02000;
    localparam logic [17:0] M_MDRO = 18'h01000;
    localparam logic [17:0] M_IRI  = 18'h00800;
    localparam logic [17:0] M_YIN  = 18'h00400;
    localparam logic [17:0] M_ZIN  = 18'h00200;
    localparam logic [17:0] M_ZLO  = 18'h00100;
    localparam logic [17:0] M_ZHI  = 18'h00080;
    localparam logic [17:0] M_HIIN = 18'h00040;
    localparam logic [17:0] M_LOIN = 18'h00020;
    localparam logic [17:0] M_ROE  = 18'h00010;
    localparam logic [17:0] M_RIE  = 18'h00008;
    localparam logic [17:0] M_BUSY = 18'h00004;
    localparam logic [17:0] M_DONE = 18'h00002;
    localparam logic [17:0] M_ERR  = 18'h00001;

    localparam logic [17:0] X_T0 = M_PC | M_MAR | M_INC | M_ZIN | M_BUSY;
    localparam logic [17:0] X_T1 = M_ZLO | M_MRD | M_MDRI | M_BUSY;
    localparam logic [17:0] X_T2 = M_MDRO | M_IRI | M_BUSY;

    alu_instr_sequencer dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .ir          (ir),
        .mem_ready   (mem_ready),
        .pc_out      (pc_out),
        .mar_in      (mar_in),
        .inc_pc      (inc_pc),
        .mem_read    (mem_read),
        .mdr_in      (mdr_in),
        .mdr_out     (mdr_out),
        .ir_in       (ir_in),
        .y_in        (y_in),
        .z_in        (z_in),
        .zlo_out     (zlo_out),
        .zhi_out     (zhi_out),
        .hi_in       (hi_in),
        .lo_in       (lo_in),
        .reg_out_en  (reg_out_en),
        .reg_out_sel (reg_out_sel),
        .reg_in_en   (reg_in_en),
        .reg_in_sel  (reg_in_sel),
        .alu_op      (alu_op),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] strb();
        return {pc_out, mar_in, inc_pc, mem_read, mdr_in, mdr_out, ir_in,
                y_in, z_in, zlo_out, zhi_out, hi_in, lo_in,
                reg_out_en, reg_in_en, busy, done, err};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the current cycle, then advance one clock.
    task automatic step(input string tag, input logic [17:0] s,
                        input logic [3:0] osel, input logic [3:0] isel,
                        input logic [4:0] op);
        int drv;
        drv = int'(pc_out) + int'(zlo_out) + int'(zhi_out)
            + int'(mdr_out) + int'(reg_out_en);
        chk({tag, "_strb"}, 32'(strb()), 32'(s));
        chk({tag, "_osel"}, 32'(reg_out_sel), 32'(osel));
        chk({tag, "_isel"}, 32'(reg_in_sel), 32'(isel));
        chk({tag, "_op"}, 32'(alu_op), 32'(op));
        chk({tag, "_onedrv"}, 32'(drv <= 1), 32'd1);
        tick();
    endtask

    task automatic go(input logic [31:0] instr);
        ir    = instr;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic fetch(input int waits);
        mem_ready = 1'b0;
        step("t0", X_T0, 0, 0, 0);
        for (int w = 0; w <= waits; w++) begin
            mem_ready = (w == waits);
            step("t1", X_T1, 0, 0, 0);
        end
        step("t2", X_T2, 0, 0, 0);
    endtask

    initial begin
        clr       = 1'b0;
        start     = 1'b0;
        ir        = 32'h0;
        mem_ready = 1'b1;
        tick();
        tick();
        clr = 1'b1;
        step("reset", 18'h0, 0, 0, 0);

        // ADD R3,R1,R2: ra=3 rb=1 rc=2
        go(32'h1989_0000);
        fetch(0);
        step("add_t3", M_ROE | M_YIN | M_BUSY, 4'd1, 0, 0);
        step("add_t4", M_ROE | M_ZIN | M_BUSY, 4'd2, 0, 5'b00011);
        step("add_t5", M_ZLO | M_RIE | M_BUSY, 0, 4'd3, 0);
        step("add_done", M_DONE | M_BUSY, 0, 0, 0);
        step("add_idle", 18'h0, 0, 0, 0);

        // MUL R5,R6 with three memory wait cycles
        go(32'h7AB0_0000);
        fetch(3);
        step("mul_t3", M_ROE | M_YIN | M_BUSY, 4'd5, 0, 0);
        step("mul_t4", M_ROE | M_ZIN | M_BUSY, 4'd6, 0, 5'b01111);
        step("mul_t5", M_ZLO | M_LOIN | M_BUSY, 0, 0, 0);
        step("mul_t6", M_ZHI | M_HIIN | M_BUSY, 0, 0, 0);
        step("mul_done", M_DONE | M_BUSY, 0, 0, 0);
        step("mul_idle", 18'h0, 0, 0, 0);

        // NEG R4,R7
        go(32'h8A38_0000);
        fetch(0);
        step("neg_t3", M_ROE | M_ZIN | M_BUSY, 4'd7, 0, 5'b10001);
        step("neg_t4", M_ZLO | M_RIE | M_BUSY, 0, 4'd4, 0);
        step("neg_done", M_DONE | M_BUSY, 0, 0, 0);
        step("neg_idle", 18'h0, 0, 0, 0);

        // Illegal opcode 11111, then a normal instruction
        go(32'hF800_0000);
        fetch(0);
        step("ill_t3", M_BUSY, 0, 0, 0);
        step("ill_err", M_ERR | M_BUSY, 0, 0, 0);
        step("ill_idle", 18'h0, 0, 0, 0);
        go(32'h8A38_0000);
        fetch(0);
        step("post_t3", M_ROE | M_ZIN | M_BUSY, 4'd7, 0, 5'b10001);
        step("post_t4", M_ZLO | M_RIE | M_BUSY, 0, 4'd4, 0);
        step("post_done", M_DONE | M_BUSY, 0, 0, 0);
        step("post_idle", 18'h0, 0, 0, 0);

        // Memory never ready: 15 wait cycles then error
        go(32'h1989_0000);
        mem_ready = 1'b0;
        step("to_t0", X_T0, 0, 0, 0);
        for (int w = 0; w < 15; w++) step("to_t1", X_T1, 0, 0, 0);
        step("to_err", M_ERR | M_BUSY, 0, 0, 0);
        step("to_idle", 18'h0, 0, 0, 0);

        // DIV R1,R2 aborted by reset in T4
        go(32'h8090_0000);
        fetch(0);
        step("div_t3", M_ROE | M_YIN | M_BUSY, 4'd1, 0, 0);
        clr = 1'b0;
        step("div_t4", M_ROE | M_ZIN | M_BUSY, 4'd2, 0, 5'b10000);
        clr = 1'b1;
        step("abort", 18'h0, 0, 0, 0);
        step("abort_idle", 18'h0, 0, 0, 0);

        // start held through a whole NEG: no extra instruction queued
        ir    = 32'h8A38_0000;
        start = 1'b1;
        tick();
        fetch(0);
        step("hold_t3", M_ROE | M_ZIN | M_BUSY, 4'd7, 0, 5'b10001);
        step("hold_t4", M_ZLO | M_RIE | M_BUSY, 0, 4'd4, 0);
        step("hold_done", M_DONE | M_BUSY, 0, 0, 0);
        start = 1'b0;
        step("hold_idle", 18'h0, 0, 0, 0);
        step("hold_idle2", 18'h0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
